pixel_output_formatter: RTL and testbench

Decoder output stage directly downstream of the YCoCg-to-RGB converter. It accepts one clamped RGB pixel per cycle under a valid/ready handshake and MSB-aligns each component to 12 bits according to `maxPoint`. It buffers pixels in a 4-entry FIFO and emits them on a 36-bit pixel bus with start-of-frame, end-of-line and end-of-frame markers derived from programmed frame dimensions.

---
 rtl/pixel_output_formatter_pkg.sv | 31 +++
 rtl/pixel_output_formatter_fifo.sv | 61 ++++++
 rtl/pixel_output_formatter.sv | 166 ++++++++++++++++
 tb/tb_pixel_output_formatter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_output_formatter_pkg.sv
// Shared types and constants for the pixel output formatter.
package pixel_output_formatter_pkg;

  // maxPoint encodings for the supported component depths
  localparam logic [12:0] MAXPT_8B  = 13'd255;
  localparam logic [12:0] MAXPT_10B = 13'd1023;
  localparam logic [12:0] MAXPT_12B = 13'd4095;

  localparam int unsigned PixW   = 36;
  localparam int unsigned EntryW = PixW + 3;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDrain
  } state_e;

  // One FIFO entry: aligned pixel word plus its frame markers
  typedef struct packed {
    logic [PixW-1:0] data;
    logic            sof;
    logic            eol;
    logic            eof;
  } fifo_entry_t;

  // MSB-align one component; bits shifted past bit 11 are dropped
  function automatic logic [11:0] align_comp(input logic [11:0] comp, input logic [2:0] shift);
    return comp << shift;
  endfunction

endpackage

// File: rtl/pixel_output_formatter_fifo.sv
// Synchronous FIFO with registered storage; head entry read directly from the array.
module pix_sync_fifo #(
  parameter int unsigned Width = 39,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] PtrOne = {{AddrW{1'b0}}, 1'b1};

  logic [AddrW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic             push_en, pop_en;

  // Extra pointer bit tells full (MSBs differ) from empty (pointers equal)
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  // Next-state for storage and pointers
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_en) begin
      mem_d[wptr_q[AddrW-1:0]] = wdata_i;
      wptr_d = wptr_q + PtrOne;
    end
    if (pop_en) begin
      rptr_d = rptr_q + PtrOne;
    end
  end

  // Storage and pointer registers; storage cleared so the idle head reads zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/pixel_output_formatter.sv
// Output stage: aligns RGB components, tags frame markers and buffers pixels.
module pixel_output_formatter
  import pixel_output_formatter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIM_W      = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [12:0]      maxPoint,
  input  logic [DIM_W-1:0] frame_width,
  input  logic [DIM_W-1:0] frame_height,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_r,
  input  logic [11:0]      in_g,
  input  logic [11:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [35:0]      out_data,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic             frame_done,
  output logic             range_err
);

  localparam logic [DIM_W-1:0] DimOne = DIM_W'(1);

  state_e           state_q, state_d;
  logic [DIM_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [DIM_W-1:0] width_q, width_d, height_q, height_d;
  logic             range_err_q, range_err_d;

  logic             fifo_full, fifo_empty, accept, pop;
  logic             tag_sof, tag_eol, tag_eof, comp_over;
  logic [2:0]       shift_amt;
  logic [12:0]      comp_limit;
  fifo_entry_t      push_entry, head_entry;

  // Decode component depth; unrecognised maxPoint falls back to 8 bpc
  always_comb begin
    shift_amt  = 3'd4;
    comp_limit = MAXPT_8B;
    case (maxPoint)
      MAXPT_10B: begin
        shift_amt  = 3'd2;
        comp_limit = MAXPT_10B;
      end
      MAXPT_12B: begin
        shift_amt  = 3'd0;
        comp_limit = MAXPT_12B;
      end
      default: begin
        shift_amt  = 3'd4;
        comp_limit = MAXPT_8B;
      end
    endcase
  end

  assign in_ready  = (state_q == StActive) && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  assign tag_sof   = (x_cnt_q == '0) && (y_cnt_q == '0);
  assign tag_eol   = (x_cnt_q == width_q - DimOne);
  assign tag_eof   = tag_eol && (y_cnt_q == height_q - DimOne);
  assign comp_over = ({1'b0, in_r} > comp_limit) || ({1'b0, in_g} > comp_limit) ||
                     ({1'b0, in_b} > comp_limit);

  // Assemble the entry pushed on accept
  always_comb begin
    push_entry.data = {align_comp(in_r, shift_amt), align_comp(in_g, shift_amt),
                       align_comp(in_b, shift_amt)};
    push_entry.sof  = tag_sof;
    push_entry.eol  = tag_eol;
    push_entry.eof  = tag_eof;
  end

  pix_sync_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (accept),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // FSM next-state, position counters and sticky range error
  always_comb begin
    state_d     = state_q;
    x_cnt_d     = x_cnt_q;
    y_cnt_d     = y_cnt_q;
    width_d     = width_q;
    height_d    = height_q;
    range_err_d = range_err_q;
    case (state_q)
      StIdle: begin
        if (start && (frame_width != '0) && (frame_height != '0)) begin
          state_d     = StActive;
          width_d     = frame_width;
          height_d    = frame_height;
          x_cnt_d     = '0;
          y_cnt_d     = '0;
          range_err_d = 1'b0;
        end
      end
      StActive: begin
        if (accept) begin
          if (comp_over) begin
            range_err_d = 1'b1;
          end
          if (tag_eol) begin
            x_cnt_d = '0;
            y_cnt_d = y_cnt_q + DimOne;
          end else begin
            x_cnt_d = x_cnt_q + DimOne;
          end
          if (tag_eof) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && head_entry.eof) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      width_q     <= '0;
      height_q    <= '0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      width_q     <= width_d;
      height_q    <= height_d;
      range_err_q <= range_err_d;
    end
  end

  assign out_data   = head_entry.data;
  assign out_sof    = head_entry.sof;
  assign out_eol    = head_entry.eol;
  assign out_eof    = head_entry.eof;
  assign frame_done = (state_q == StDrain) && pop && head_entry.eof;
  assign range_err  = range_err_q;

endmodule

// File: tb/tb_pixel_output_formatter.sv
// Directed bench for pixel_output_formatter: vector table plus frame sequences.
module tb_pixel_output_formatter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] maxPoint;
  logic [12:0] frame_width, frame_height;
  logic        start, in_valid, in_ready, out_valid, out_ready;
  logic [11:0] in_r, in_g, in_b;
  logic [35:0] out_data;
  logic        out_sof, out_eol, out_eof, frame_done, range_err;

  int total = 0;
  int bad   = 0;

  pixel_output_formatter #(
    .FIFO_DEPTH (4),
    .DIM_W      (13)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .maxPoint     (maxPoint),
    .frame_width  (frame_width),
    .frame_height (frame_height),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_r         (in_r),
    .in_g         (in_g),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sof      (out_sof),
    .out_eol      (out_eol),
    .out_eof      (out_eof),
    .frame_done   (frame_done),
    .range_err    (range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] mp;
    logic [11:0] r, g, b;
    logic [35:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int w, input int h);
    frame_width  = 13'(w);
    frame_height = 13'(h);
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Runs a whole 8 bpc frame; pixel i carries components base + i*inc.
  // out_ready is held low for cycles [stall_lo, stall_hi). A stray start is
  // pulsed once the accept count reaches mid_start.
  task automatic run_frame(input int w, input int h, input logic [11:0] r0, input logic [11:0] g0,
                           input logic [11:0] b0, input int inc, input int stall_lo,
                           input int stall_hi, input int mid_start);
    int          n;
    int          acc;
    int          pops;
    logic        held_v;
    logic        mid_done;
    logic [35:0] held;
    logic [11:0] er, eg, eb;
    n        = w * h;
    acc      = 0;
    pops     = 0;
    held_v   = 1'b0;
    mid_done = 1'b0;
    held     = '0;
    maxPoint = 13'd255;
    do_start(w, h);
    for (int c = 0; c < 400 && pops < n; c++) begin
      out_ready = !(c >= stall_lo && c < stall_hi);
      in_valid  = (acc < n);
      in_r      = r0 + 12'(acc * inc);
      in_g      = g0 + 12'(acc * inc);
      in_b      = b0 + 12'(acc * inc);
      start     = 1'b0;
      if (acc == mid_start && !mid_done) begin
        start        = 1'b1;
        frame_width  = 13'd1;
        frame_height = 13'd1;
        mid_done     = 1'b1;
      end
      #1;
      if (out_valid) begin
        er = r0 + 12'(pops * inc);
        eg = g0 + 12'(pops * inc);
        eb = b0 + 12'(pops * inc);
        check("frm_data", out_data, {er[7:0], 4'h0, eg[7:0], 4'h0, eb[7:0], 4'h0});
        check("frm_sof", out_sof, pops == 0);
        check("frm_eol", out_eol, (pops % w) == w - 1);
        check("frm_eof", out_eof, pops == n - 1);
        check("frm_done", frame_done, out_ready && (pops == n - 1));
        if (held_v) check("hold_stable", out_data, held);
        held_v = !out_ready;
        held   = out_data;
        if (out_ready) pops++;
      end else begin
        held_v = 1'b0;
      end
      if (stall_hi > stall_lo && c == stall_hi - 1) begin
        check("bp_accepts", acc, 4);
        check("bp_in_ready", in_ready, 0);
      end
      if (in_valid && in_ready) acc++;
      tick();
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    check("frm_count", pops, n);
    check("frm_idle_in_ready", in_ready, 0);
    check("frm_idle_out_valid", out_valid, 0);
  endtask

  initial begin
    int acc;
    vecs[0] = '{13'd255,  12'h0AB, 12'h012, 12'h0FF, 36'hAB0_120_FF0, 1'b0};
    vecs[1] = '{13'd1023, 12'h3FF, 12'h000, 12'h001, 36'hFFC_000_004, 1'b0};
    vecs[2] = '{13'd4095, 12'hFFF, 12'h123, 12'h000, 36'hFFF_123_000, 1'b0};
    vecs[3] = '{13'd255,  12'h000, 12'h1FF, 12'h000, 36'h000_FF0_000, 1'b1};
    vecs[4] = '{13'd1023, 12'h400, 12'h000, 12'h000, 36'h000_000_000, 1'b1};
    vecs[5] = '{13'd100,  12'h010, 12'h020, 12'h030, 36'h100_200_300, 1'b0};
    vecs[6] = '{13'd100,  12'h100, 12'h000, 12'h000, 36'h000_000_000, 1'b1};

    rst_n        = 1'b0;
    maxPoint     = 13'd255;
    frame_width  = '0;
    frame_height = '0;
    start        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    in_r         = '0;
    in_g         = '0;
    in_b         = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_markers", {out_sof, out_eol, out_eof}, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_range_err", range_err, 0);

    // Single-pixel frames through the vector table
    for (int i = 0; i < 7; i++) begin
      maxPoint = vecs[i].mp;
      do_start(1, 1);
      check("tbl_err_clr", range_err, 0);
      check("tbl_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_r     = vecs[i].r;
      in_g     = vecs[i].g;
      in_b     = vecs[i].b;
      tick();
      in_valid = 1'b0;
      check("tbl_out_valid", out_valid, 1);
      check("tbl_data", out_data, vecs[i].exp_data);
      check("tbl_markers", {out_sof, out_eol, out_eof}, 3'b111);
      check("tbl_err", range_err, vecs[i].exp_err);
      check("tbl_drain_in_ready", in_ready, 0);
      out_ready = 1'b1;
      #1;
      check("tbl_frame_done", frame_done, 1);
      tick();
      out_ready = 1'b0;
      check("tbl_empty", out_valid, 0);
      check("tbl_done_clr", frame_done, 0);
      check("tbl_err_sticky", range_err, vecs[i].exp_err);
    end

    // 4x2 frame, free-running output
    run_frame(4, 2, 12'h0AB, 12'h012, 12'h0FF, 0, 0, 0, -1);
    // 3x3 frame with output stalled for the first 10 cycles
    run_frame(3, 3, 12'h010, 12'h020, 12'h030, 1, 0, 10, -1);
    // Stray start in mid-frame must not disturb the 2x2 tagging
    run_frame(2, 2, 12'h001, 12'h002, 12'h003, 1, 0, 0, 1);

    // Zero dimension starts are ignored
    do_start(0, 3);
    check("zw_in_ready", in_ready, 0);
    tick();
    check("zw_in_ready2", in_ready, 0);
    do_start(3, 0);
    check("zh_in_ready", in_ready, 0);
    check("zh_out_valid", out_valid, 0);

    // Reset in the middle of a 4x4 frame
    maxPoint  = 13'd255;
    out_ready = 1'b1;
    do_start(4, 4);
    acc = 0;
    for (int c = 0; c < 50 && acc < 5; c++) begin
      in_valid = 1'b1;
      in_r     = 12'(acc);
      #1;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    check("mid_accepts", acc, 5);
    check("mid_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_done", frame_done, 0);
    tick();
    out_ready = 1'b0;
    rst_n     = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 0);
    run_frame(2, 2, 12'h005, 12'h006, 12'h007, 1, 0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
